// File: rtl/shift_issue_stage.sv
// Shift issue stage: one operand register feeding an external logical-right shifter,
// followed by a circular result FIFO with zero/overflow flags and a delivery counter.
module shift_issue_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_movement,
    input  logic [3:0]  in_tag,
    output logic [31:0] sh_a,
    output logic [31:0] sh_movement,
    input  logic [31:0] sh_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_zero,
    output logic        out_ovr,
    output logic [3:0]  out_tag,
    output logic [15:0] op_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic              s1_v_q, s1_v_d;
    logic [31:0]       s1_a_q, s1_a_d;
    logic [4:0]        s1_amt_q, s1_amt_d;
    logic              s1_ovr_q, s1_ovr_d;
    logic [3:0]        s1_tag_q, s1_tag_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       op_count_q, op_count_d;

    logic [31:0] buf_data [DEPTH];
    logic        buf_zero [DEPTH];
    logic        buf_ovr  [DEPTH];
    logic [3:0]  buf_tag  [DEPTH];

    logic        full, empty, pop, advance, accept;
    logic [31:0] wr_data;

    always_comb begin
        full    = (cnt_q == FULL_CNT);
        empty   = (cnt_q == '0);
        pop     = !empty && out_ready;
        advance = s1_v_q && (!full || pop);
        accept  = in_valid && in_ready;
        wr_data = s1_ovr_q ? '0 : sh_out;
    end

    assign in_ready = !s1_v_q || advance;

    // The operand fields are cleared when the stage drains so the shifter
    // inputs read as zero whenever no operation is held.
    always_comb begin
        s1_v_d   = s1_v_q;
        s1_a_d   = s1_a_q;
        s1_amt_d = s1_amt_q;
        s1_ovr_d = s1_ovr_q;
        s1_tag_d = s1_tag_q;
        if (accept) begin
            s1_v_d   = 1'b1;
            s1_a_d   = in_a;
            s1_amt_d = in_movement[4:0];
            s1_ovr_d = |in_movement[31:5];
            s1_tag_d = in_tag;
        end else if (advance) begin
            s1_v_d   = 1'b0;
            s1_a_d   = '0;
            s1_amt_d = '0;
            s1_ovr_d = 1'b0;
            s1_tag_d = '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (advance) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        case ({advance, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        op_count_d = op_count_q;
        if (pop && (op_count_q != 16'hFFFF)) op_count_d = op_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_a_q     <= '0;
            s1_amt_q   <= '0;
            s1_ovr_q   <= 1'b0;
            s1_tag_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            op_count_q <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_a_q     <= s1_a_d;
            s1_amt_q   <= s1_amt_d;
            s1_ovr_q   <= s1_ovr_d;
            s1_tag_q   <= s1_tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            op_count_q <= op_count_d;
        end
    end

    // Storage needs no reset: every read is masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (advance) begin
            buf_data[wr_ptr_q] <= wr_data;
            buf_zero[wr_ptr_q] <= (wr_data == '0);
            buf_ovr[wr_ptr_q]  <= s1_ovr_q;
            buf_tag[wr_ptr_q]  <= s1_tag_q;
        end
    end

    assign sh_a        = s1_a_q;
    assign sh_movement = {27'b0, s1_amt_q};
    assign out_valid   = !empty;
    assign out_data    = empty ? '0   : buf_data[rd_ptr_q];
    assign out_zero    = empty ? 1'b0 : buf_zero[rd_ptr_q];
    assign out_ovr     = empty ? 1'b0 : buf_ovr[rd_ptr_q];
    assign out_tag     = empty ? '0   : buf_tag[rd_ptr_q];
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Scoreboard bench for shift_issue_stage: expected results are queued at acceptance
// from an arithmetic model and popped by an independent output monitor.
module tb_shift_issue_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_movement = '0;
    logic [3:0]  in_tag = '0;
    logic [31:0] sh_a, sh_movement, sh_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_zero, out_ovr;
    logic [3:0]  out_tag;
    logic [15:0] op_count;

    shift_issue_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_movement(in_movement), .in_tag(in_tag),
        .sh_a(sh_a), .sh_movement(sh_movement), .sh_out(sh_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .out_ovr(out_ovr), .out_tag(out_tag),
        .op_count(op_count)
    );

    // External combinational shifter.
    assign sh_out = sh_a >> sh_movement;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        z;
        logic        o;
        logic [3:0]  t;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned model_cnt = 0;
    logic [3:0]  tag_ctr = 4'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] amt, input logic [3:0] t);
        exp_t e;
        longint unsigned v;
        v   = (amt >= 32) ? 0 : (longint'(a) / (longint'(1) << amt));
        e.d = v[31:0];
        e.z = (e.d == 0);
        e.o = (amt >= 32);
        e.t = t;
        return e;
    endfunction

    // Output monitor / scoreboard.
    logic  hold_v = 1'b0;
    exp_t  hold_e;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stable_valid", 32'(out_valid), 32'd1);
                chk("stable_fields", 32'({out_data, out_zero, out_ovr, out_tag} == hold_e), 32'd1);
            end
            chk("op_count", 32'(op_count), model_cnt);
            if (out_valid) begin
                if (out_ready) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_output", 32'(out_tag), 32'hFFFF_FFFF);
                    end else begin
                        e = sbq.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_zero", 32'(out_zero), 32'(e.z));
                        chk("out_ovr",  32'(out_ovr),  32'(e.o));
                        chk("out_tag",  32'(out_tag),  32'(e.t));
                        if (model_cnt < 65535) model_cnt++;
                    end
                end
            end else begin
                chk("empty_fields", {out_data[31:6], out_data[5:0] | {out_zero, out_ovr, out_tag}}, 32'd0);
            end
            hold_v = out_valid && !out_ready;
            hold_e = {out_data, out_zero, out_ovr, out_tag};
            if (in_valid && in_ready) sbq.push_back(model(in_a, in_movement, in_tag));
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] amt, input bit want_ready);
        bit acc;
        in_valid    = 1'b1;
        in_a        = a;
        in_movement = amt;
        in_tag      = tag_ctr;
        acc         = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            if (want_ready) chk("in_ready_stream", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        tag_ctr = tag_ctr + 4'd1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sbq.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", sbq.size(), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] amt;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_sh_a", sh_a, 32'd0);
        chk("rst_sh_movement", sh_movement, 32'd0);
        chk("rst_out_fields", {out_data[31:6], out_data[5:0] | {out_zero, out_ovr, out_tag}}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Two-cycle latency, amount 31.
        out_ready = 1'b1;
        tag_ctr   = 4'd3;
        send(32'h8000_0000, 32'd31, 1'b0);
        in_valid = 1'b0;
        chk("lat_sh_movement", sh_movement, 32'd31);
        @(posedge clk);
        #1;
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_data", out_data, 32'd1);
        chk("lat_out_tag", 32'(out_tag), 32'd3);
        @(posedge clk);
        #1;
        chk("lat_op_count", 32'(op_count), 32'd1);

        // Overflow and boundary amounts.
        send(32'hFFFF_FFFF, 32'h0000_0020, 1'b0);
        send(32'hFFFF_FFFF, 32'h0001_0004, 1'b0);
        send(32'hDEAD_BEEF, 32'd0, 1'b0);
        send(32'h7FFF_FFFF, 32'd31, 1'b0);
        send(32'h1234_5678, 32'd4, 1'b0);
        drain();

        // Back-to-back stream with continuous output.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send($urandom, 32'($urandom_range(0, 40)), 1'b1);
            if (i >= 2) chk("stream_out_valid", 32'(out_valid), 32'd1);
        end
        drain();

        // Backpressure: DEPTH entries plus the operand stage, then a single pop.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) send($urandom, 32'($urandom_range(0, 31)), 1'b0);
        in_valid = 1'b0;
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_tag", 32'(out_tag), 32'(tag_ctr - 4'(DEPTH + 1)));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("pulse_in_ready", 32'(in_ready), 32'd1);
        chk("pulse_head_tag", 32'(out_tag), 32'(tag_ctr - 4'(DEPTH)));
        @(posedge clk);
        #1;
        chk("pulse_single_pop", sbq.size(), 32'(DEPTH));

        // Full buffer with simultaneous push and pop.
        send($urandom, 32'd7, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send($urandom, 32'($urandom_range(0, 33)), 1'b1);
            chk("full_stream_valid", 32'(out_valid), 32'd1);
        end
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = $urandom;
            case ($urandom_range(0, 4))
                0: amt = 32'd0;
                1: amt = 32'd31;
                2: amt = 32'd32;
                3: amt = $urandom;
                default: amt = 32'($urandom_range(1, 30));
            endcase
            in_movement = amt;
            in_tag      = tag_ctr;
            tag_ctr     = tag_ctr + 4'd1;
            @(posedge clk);
            #1;
        end
        drain();

        // Reset with buffered and in-flight operations.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) send($urandom | 32'h1, 32'd0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        sbq.delete();
        model_cnt = 0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_op_count", 32'(op_count), 32'd0);
        chk("midrst_sh_a", sh_a, 32'd0);
        chk("midrst_out_tag", 32'(out_tag), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("no_stale_output", 32'(out_valid), 32'd0);
        end
        send(32'hF0, 32'd4, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
